column_ec_drain: RTL
====================

// Module: column_ec_drain
// PURPOSE
//  Bottom-of-column drain stage for the error-compensation MAC array. Consumes the
//  last MAC's partial sum, error product and error flag; adds the still-pending
//  error product at full precision (no further MAC exists to absorb it) and
//  buffers compensated column results in a small FWFT FIFO for the output
//  writer (valid/ready). Keeps a saturating count of timing-error events.
// PARAMETERS
//  PSUM_W      24  partial-sum / result width
//  PROD_W      16  error-product width (PROD_W <= PSUM_W)
//  FIFO_DEPTH  4   result FIFO entries, power of two, >= 2
//  CNT_W       16  error-event counter width
// PORTS
//  clk                 in   1        rising-edge clock
//  rst                 in   1        async active-high reset
//  in_valid            in   1        column output valid this cycle (no backpressure)
//  partial_sum_in      in   PSUM_W   partial_sum_out of last MAC
//  error_product_in    in   PROD_W   error_product_out of last MAC
//  error_in            in   1        error_out of last MAC
//  clr_stats           in   1        sync clear of error_count and overflow
//  out_valid           out  1        FIFO head valid
//  out_ready           in   1        consumer accepts head
//  result_out          out  PSUM_W   compensated result at FIFO head
//  result_err          out  1        head result required compensation
//  fifo_level          out  log2(FIFO_DEPTH)+1  entries held
//  error_count         out  CNT_W    saturating count of accepted error_in=1 samples
//  overflow            out  1        sticky: a result was dropped (FIFO full)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; stage register invalid. Async assert,
//   deassert synchronous to clk externally; rst mid-operation discards all data.
//  Stage 1 (edge k, in_valid=1): register psum, eprod, err.
//   comp = psum + (err ? zero_ext(eprod) : 0), modulo 2^PSUM_W (wrap, no sat).
//   error_in=0 => error_product_in ignored even if non-zero.
//   No rounding here: full PROD_W bits added.
//  Stage 2 (edge k+1): push {comp, err} into FIFO if stage valid.
//   Latency: in_valid sampled at edge k -> out_valid/result_out visible after
//   edge k+1 when FIFO was empty (2 cycles, first-word-fall-through).
//   Back-to-back in_valid sustained at 1 result/cycle.
//  Pop: out_valid && out_ready at an edge removes head.
//  Full: push when fifo_level==FIFO_DEPTH and no pop same edge -> entry dropped,
//   overflow<=1 (sticky). Push+pop same edge while full -> both occur, no drop.
//  Empty: out_valid=0, result_out/result_err hold last-popped value (don't care);
//   out_ready ignored.
//  Simultaneous push/pop with level 1..DEPTH-1: level unchanged, order kept.
//  Pointers wrap modulo FIFO_DEPTH; fifo_level distinguishes full vs empty.
//  error_count: +1 per stage-2 push with err=1 (counted even if dropped);
//   saturates at 2^CNT_W-1. clr_stats: count<=0, overflow<=0; clr_stats with
//   same-edge increment -> result 0 (clear wins). FIFO unaffected by clr_stats.
//  No combinational path from in_* to out_*; out_valid depends only on state.
// TESTING
//  1 Reset: assert rst mid-stream with 3 entries -> out_valid=0, fifo_level=0,
//    error_count=0, overflow=0 immediately (async).
//  2 psum=24'h000100, eprod=16'h0020, err=1, ready=1 -> two edges later
//    result_out=24'h000120, result_err=1, error_count=1.
//  3 psum=24'hFFFFF0, eprod=16'h0020, err=1 -> result_out=24'h000010 (wrap);
//    psum=24'h000005, eprod=16'hFFFF, err=0 -> result_out=24'h000005.
//  4 out_ready=0, 6 consecutive in_valid (DEPTH=4) -> fifo_level=4, overflow=1,
//    then out_ready=1 returns first four results in order, last two lost.
//  5 FIFO full, in_valid and out_ready every cycle for 10 cycles -> no drops,
//    overflow stays 0, level stays 4, outputs in input order.
//  6 CNT_W=4, 17 err=1 samples -> error_count=15 (saturated); clr_stats pulse
//    coincident with an err=1 push -> error_count=0.

Source files
------------

// File: rtl/column_ec_drain.sv
// -----------------------------------------------------------------------------
// column_ec_drain
//
// Bottom-of-column drain stage for the error-compensation MAC array. The last
// MAC still carries a pending error product that no downstream MAC can absorb.
// This stage adds that product at full precision and queues the compensated
// column results in a small first-word-fall-through FIFO for the output
// writer. It also keeps a saturating count of timing-error events.
//
// Pipeline:
//   edge k   : stage register captures comp = psum + (err ? eprod : 0)
//   edge k+1 : stage entry is pushed into the FIFO and is visible at the head
//
// Ports:
//   clk               in   1              rising-edge clock
//   rst               in   1              async active-high reset
//   in_valid          in   1              column output valid (no backpressure)
//   partial_sum_in    in   PSUM_W         partial sum of the last MAC
//   error_product_in  in   PROD_W         error product of the last MAC
//   error_in          in   1              error flag of the last MAC
//   clr_stats         in   1              sync clear of error_count / overflow
//   out_valid         out  1              FIFO head valid
//   out_ready         in   1              consumer accepts head
//   result_out        out  PSUM_W         compensated result at FIFO head
//   result_err        out  1              head result needed compensation
//   fifo_level        out  log2(DEPTH)+1  entries held
//   error_count       out  CNT_W          saturating count of err=1 pushes
//   overflow          out  1              sticky: a result was dropped
// -----------------------------------------------------------------------------
module column_ec_drain #(
    parameter int PSUM_W     = 24,
    parameter int PROD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [PSUM_W-1:0]             partial_sum_in,
    input  logic [PROD_W-1:0]             error_product_in,
    input  logic                          error_in,
    input  logic                          clr_stats,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PSUM_W-1:0]             result_out,
    output logic                          result_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              error_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [PSUM_W-1:0] sum;
        logic              err;
    } entry_t;

    // ------------------------------------------------------------------
    // Stage 1: compensation
    // ------------------------------------------------------------------
    logic              stg_valid_q;
    logic [PSUM_W-1:0] stg_sum_q, stg_sum_d;
    logic              stg_err_q;

    // The error product is only meaningful when the error flag is set; the
    // sum wraps modulo 2^PSUM_W, matching the array's own accumulator.
    always_comb begin
        // NOTE: always_comb assigns a default first so no path leaves the
        // signal unassigned, which would otherwise infer a latch.
        stg_sum_d = partial_sum_in;
        if (error_in) begin
            stg_sum_d = partial_sum_in + PSUM_W'(error_product_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            stg_valid_q <= 1'b0;
            stg_sum_q   <= '0;
            stg_err_q   <= 1'b0;
        end else begin
            stg_valid_q <= in_valid;
            if (in_valid) begin
                stg_sum_q <= stg_sum_d;
                stg_err_q <= error_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result FIFO
    // ------------------------------------------------------------------
    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign full = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop  = (level_q != '0) && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = stg_valid_q && (!full || pop);
    assign drop    = stg_valid_q && full && !pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset so result_out reads 0 out of reset;
            // with only a handful of entries this is cheap.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= '{sum: stg_sum_q, err: stg_err_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Error events are counted at the push point, dropped or not. Clear
    // takes priority over a same-edge increment or drop.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q | drop;
        if (stg_valid_q && stg_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clr_stats) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all driven from state only
    // ------------------------------------------------------------------
    assign out_valid   = (level_q != '0);
    assign result_out  = mem_q[rd_ptr_q].sum;
    assign result_err  = mem_q[rd_ptr_q].err;
    assign fifo_level  = level_q;
    assign error_count = cnt_q;
    assign overflow    = ovf_q;

endmodule
